// File: rtl/freq_flag_stabiliser.sv
// ---------------------------------------------------------------------------
// freq_flag_stabiliser
//
// Conditions the raw frequency class from the audio pitch detector into the
// stable freq_flag that drives the brightness/pixel filter. A class must be
// seen HOLD_COUNT times in a row before it qualifies, and a qualified change
// is only committed on a frame_start pulse so a single video frame never
// mixes two effect levels. Prolonged silence falls back to flag 0.
//
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   raw_valid    in   single-cycle strobe, raw_flag holds a new sample
//   raw_flag     in   detector class sample (FLAG_W bits)
//   frame_start  in   single-cycle pulse at the start of each video frame
//   freq_flag    out  stable, registered flag (FLAG_W bits)
//   flag_changed out  one-cycle pulse on the first cycle of a new freq_flag
//   pending      out  a qualified change is waiting for frame_start
// ---------------------------------------------------------------------------
module freq_flag_stabiliser #(
  parameter int FLAG_W         = 3,
  parameter int MAX_FLAG       = 4,
  parameter int HOLD_COUNT     = 4,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              raw_valid,
  input  logic [FLAG_W-1:0] raw_flag,
  input  logic              frame_start,
  output logic [FLAG_W-1:0] freq_flag,
  output logic              flag_changed,
  output logic              pending
);

  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IDLE_W-1:0] TIMEOUT_VAL = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]        HOLD_VAL    = 4'(HOLD_COUNT);
  localparam logic [FLAG_W-1:0] MAX_VAL     = FLAG_W'(MAX_FLAG);
  localparam bit                TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

  logic [FLAG_W-1:0] candidate_q,    candidate_d;
  logic [3:0]        streak_q,       streak_d;
  logic [FLAG_W-1:0] pending_flag_q, pending_flag_d;
  logic              pending_q,      pending_d;
  logic [FLAG_W-1:0] freq_flag_q,    freq_flag_d;
  logic              changed_q,      changed_d;
  logic [IDLE_W-1:0] idle_q,         idle_d;

  logic sample_ok;
  logic timeout_hit;
  logic commit;

  // Out-of-range samples are treated exactly as if no strobe occurred.
  assign sample_ok = raw_valid && (raw_flag <= MAX_VAL);

  // Fires on the edge where the idle counter reaches TIMEOUT_CYCLES; the
  // counter then parks there, so only one fallback happens per silence gap.
  assign timeout_hit = TIMEOUT_EN && !sample_ok && (idle_q == TIMEOUT_VAL - 1'b1);

  assign commit = frame_start && pending_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through
    // this block leaves one unassigned, which would infer a latch.
    candidate_d    = candidate_q;
    streak_d       = streak_q;
    pending_flag_d = pending_flag_q;
    pending_d      = pending_q;
    freq_flag_d    = freq_flag_q;
    changed_d      = 1'b0;
    idle_d         = idle_q;

    // Silence tracking.
    if (sample_ok) begin
      idle_d = '0;
    end else if (TIMEOUT_EN && (idle_q != TIMEOUT_VAL)) begin
      idle_d = idle_q + 1'b1;
    end

    // Candidate / streak update.
    if (sample_ok) begin
      if (raw_flag == candidate_q) begin
        if (streak_q != HOLD_VAL) streak_d = streak_q + 4'd1;
      end else begin
        candidate_d = raw_flag;
        streak_d    = 4'd1;
      end
    end else if (timeout_hit) begin
      candidate_d = '0;
      streak_d    = HOLD_VAL;
    end

    // Commit uses the pending_flag held before this edge.
    if (commit) begin
      freq_flag_d = pending_flag_q;
      pending_d   = 1'b0;
      changed_d   = 1'b1;
    end

    // Qualification on the registered streak, compared against the value
    // freq_flag will hold after this edge so a same-edge commit is honoured.
    if (streak_q == HOLD_VAL) begin
      if (candidate_q != freq_flag_d) begin
        pending_d      = 1'b1;
        pending_flag_d = candidate_q;
      end else begin
        pending_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      candidate_q    <= '0;
      streak_q       <= '0;
      pending_flag_q <= '0;
      pending_q      <= 1'b0;
      freq_flag_q    <= '0;
      changed_q      <= 1'b0;
      idle_q         <= '0;
    end else begin
      candidate_q    <= candidate_d;
      streak_q       <= streak_d;
      pending_flag_q <= pending_flag_d;
      pending_q      <= pending_d;
      freq_flag_q    <= freq_flag_d;
      changed_q      <= changed_d;
      idle_q         <= idle_d;
    end
  end

  assign freq_flag    = freq_flag_q;
  assign flag_changed = changed_q;
  assign pending      = pending_q;

endmodule
